// File: rtl/apb_wait_mem_slv_if.sv
`default_nettype none
// ============================================================================
// Module   : apb_wait_mem_slv_if
// Brief    : APB4 signal bundle with requester (master) / completer (slave) views.
// Revision : 1.0 - initial release
// ============================================================================
interface apb_wait_mem_slv_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    psel;
  logic                    penable;
  logic [ADDR_WIDTH-1:0]   paddr;
  logic                    pwrite;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic                    pready;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pslverr;

  modport master (
    output psel, penable, paddr, pwrite, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, paddr, pwrite, pwdata, pstrb,
    output pready, prdata, pslverr
  );
endinterface
`default_nettype wire

// File: rtl/apb_wait_mem_slv.sv
`default_nettype none
// ============================================================================
// Module   : apb_wait_mem_slv
// Brief    : APB4 completer RAM with programmable wait states, byte strobes
//            and PSLVERR on out-of-range or misaligned accesses.
// Revision : 1.0 - initial release
// ============================================================================
module apb_wait_mem_slv #(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           DEPTH       = 256,
  parameter int unsigned           WAIT_STATES = 0,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
  input  wire logic         clk_i,
  input  wire logic         rst_ni,
  apb_wait_mem_slv_if.slave bus
);

  localparam int unsigned           C_BYTES     = DATA_WIDTH / 8;
  localparam int unsigned           C_ALIGN     = (C_BYTES > 1) ? $clog2(C_BYTES) : 0;
  localparam int unsigned           C_IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]   C_MEM_BYTES = (ADDR_WIDTH + 1)'(DEPTH * C_BYTES);
  localparam logic [3:0]            C_WAIT      = 4'(WAIT_STATES);
  localparam logic                  C_NO_WAIT   = (WAIT_STATES == 0);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  state_t                  state_q;
  logic [3:0]              cnt_q;
  logic [C_IDX_W-1:0]      idx_q;
  logic                    write_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [C_BYTES-1:0]      strb_q;
  logic                    err_q;
  logic                    pready_q;
  logic                    pslverr_q;
  logic [DATA_WIDTH-1:0]   prdata_q;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic [ADDR_WIDTH:0]     w_diff;
  logic                    w_below;
  logic                    w_range;
  logic                    w_misalign;
  logic                    w_err;
  logic [C_IDX_W-1:0]      w_idx;
  logic [DATA_WIDTH-1:0]   w_rdata;
  logic                    w_start;
  logic                    w_access;
  logic                    w_commit;

  // The extra MSB of the difference is the borrow, i.e. PADDR below the base.
  assign w_diff  = {1'b0, bus.paddr} - {1'b0, BASE_ADDR};
  assign w_below = w_diff[ADDR_WIDTH];
  assign w_range = (w_diff >= C_MEM_BYTES);
  assign w_idx   = w_diff[C_ALIGN +: C_IDX_W];

  generate
    if (C_ALIGN > 0) begin : g_align_chk
      assign w_misalign = |w_diff[C_ALIGN-1:0];
    end else begin : g_align_none
      assign w_misalign = 1'b0;
    end
  endgenerate

  assign w_err    = w_below | w_range | w_misalign;
  assign w_rdata  = mem_q[w_idx];

  // A setup cycle starts a transfer from any state; in ACCESS it doubles as an abort.
  assign w_start  = bus.psel & ~bus.penable;
  assign w_access = bus.psel & bus.penable;
  assign w_commit = (state_q == S_ACCESS) & w_access & (cnt_q == 4'd0) & write_q & ~err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      idx_q     <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      err_q     <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      if (w_start) begin
        state_q   <= S_ACCESS;
        cnt_q     <= C_WAIT;
        idx_q     <= w_idx;
        write_q   <= bus.pwrite;
        wdata_q   <= bus.pwdata;
        strb_q    <= bus.pstrb;
        err_q     <= w_err;
        pready_q  <= C_NO_WAIT;
        pslverr_q <= C_NO_WAIT & w_err;
        if (!bus.pwrite) begin
          prdata_q <= w_err ? '0 : w_rdata;
        end
      end else if (state_q == S_ACCESS) begin
        if (w_access && (cnt_q != 4'd0)) begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            pready_q  <= 1'b1;
            pslverr_q <= err_q;
          end
        end else begin
          // Completing cycle or protocol abort both end the transfer.
          state_q <= S_IDLE;
          cnt_q   <= 4'd0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_commit) begin
      for (int b = 0; b < int'(C_BYTES); b++) begin
        if (strb_q[b]) begin
          mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

  assign bus.pready  = pready_q;
  assign bus.pslverr = pslverr_q;
  assign bus.prdata  = prdata_q;

endmodule
`default_nettype wire
